// File: rtl/dequant_4x4.sv
// dequant_4x4: inverse quantizer for 4x4 residual blocks.
// Accepts 16 signed levels per block, rescales one row of four per cycle by
// the position-dependent scale V[qp%6] shifted left by qp/6, then holds the
// block until the inverse transform consumes it.
// Optional feature macro: DEQUANT_SAT_EN -- when defined, every result
// (including the dc_skip passthrough) saturates to the signed OUT_WIDTH
// range; when undefined, results wrap to the low OUT_WIDTH bits.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a source holds valid (and its data) stable until it sees ready, and
// ready never depends on a transfer being in progress in the same cycle.
module dequant_4x4 #(
    parameter int BIT_LENGTH = 15,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [5:0]                   qp,
    input  logic                         dc_skip,
    input  logic signed [BIT_LENGTH:0]   quantized [16],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  dequantized [16],
    output logic [1:0]                   dbg_state
);

    // Intermediate wide enough for level * scale << 8 with no overflow.
    localparam int PW = BIT_LENGTH + 1 + 5 + 8 + 1;

    localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [1:0]                   row;
    logic [5:0]                   qp_r;
    logic                         dc_skip_r;
    logic signed [BIT_LENGTH:0]   z_r [16];
    logic                         accept;
    logic [3:0]                   qp_div;
    logic [2:0]                   qp_mod;
    logic signed [OUT_WIDTH-1:0]  row_result [4];

    // Scale for a coefficient at (r, c): class a = even/even, class b = odd/odd.
    function automatic logic [4:0] scale_of(input logic [1:0] r, input logic [1:0] c,
                                            input logic [2:0] m);
        logic [4:0] v;
        v = 5'd0;
        if (!r[0] && !c[0]) begin
            case (m)
                3'd0: v = 5'd10;
                3'd1: v = 5'd11;
                3'd2: v = 5'd13;
                3'd3: v = 5'd14;
                3'd4: v = 5'd16;
                default: v = 5'd18;
            endcase
        end else if (r[0] && c[0]) begin
            case (m)
                3'd0: v = 5'd16;
                3'd1: v = 5'd18;
                3'd2: v = 5'd20;
                3'd3: v = 5'd23;
                3'd4: v = 5'd25;
                default: v = 5'd29;
            endcase
        end else begin
            case (m)
                3'd0: v = 5'd13;
                3'd1: v = 5'd14;
                3'd2: v = 5'd16;
                3'd3: v = 5'd18;
                3'd4: v = 5'd20;
                default: v = 5'd23;
            endcase
        end
        return v;
    endfunction

    // Reduce a wide signed result to the output width.
    function automatic logic signed [OUT_WIDTH-1:0] fit(input logic signed [PW-1:0] v);
`ifdef DEQUANT_SAT_EN
        if (v > SAT_MAX) begin
            return OUT_WIDTH'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return OUT_WIDTH'(SAT_MIN);
        end
        return OUT_WIDTH'(v);
`else
        return OUT_WIDTH'(v);
`endif
    endfunction

    // Rescale one level; pass selects the unscaled DC path.
    function automatic logic signed [OUT_WIDTH-1:0] rescale(input logic signed [BIT_LENGTH:0] z,
                                                            input logic [4:0] v,
                                                            input logic [3:0] sh,
                                                            input logic pass);
        logic signed [PW-1:0] z_ext;
        logic signed [PW-1:0] prod;
        z_ext = PW'(z);
        prod  = (z_ext * $signed(PW'(v))) <<< sh;
        return pass ? fit(z_ext) : fit(prod);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = PROC;
            PROC: if (row == 2'd3) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = accept ? PROC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs and debug view of the state.
    always_comb begin
        in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && !reset;
        accept    = in_valid && in_ready;
        dbg_state = state;
    end

    // Split the captured qp into shift and scale-table index.
    always_comb begin
        qp_div = 4'(qp_r / 6'd6);
        qp_mod = 3'(qp_r % 6'd6);
    end

    // Rescale the four coefficients of the current row.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            row_result[c] = rescale(z_r[{row, 2'(c)}], scale_of(row, 2'(c), qp_mod), qp_div,
                                    dc_skip_r && (row == 2'd0) && (c == 0));
        end
    end

    // Block capture, row write-back and out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row       <= 2'd0;
            out_valid <= 1'b0;
            qp_r      <= 6'd0;
            dc_skip_r <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                z_r[i]         <= '0;
                dequantized[i] <= '0;
            end
        end else begin
            if (accept) begin
                z_r       <= quantized;
                qp_r      <= (qp > 6'd51) ? 6'd51 : qp;
                dc_skip_r <= dc_skip;
                row       <= 2'd0;
                out_valid <= 1'b0;
            end else if (state == PROC) begin
                for (int c = 0; c < 4; c++) begin
                    dequantized[{row, 2'(c)}] <= row_result[c];
                end
                row <= row + 2'd1;
                if (row == 2'd3) begin
                    out_valid <= 1'b1;
                end
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dequant_4x4.md
# dequant_4x4

Inverse quantizer (rescaler) for 4x4 residual blocks. It sits on the decoder/reconstruction side, between the coefficient source (entropy decoder or the forward quantizer's loopback) and the inverse transform. It accepts a full block of 16 quantized levels with a valid/ready handshake and rescales one row of four coefficients per cycle by the position-dependent scale for a runtime QP. It presents the reconstructed block to the inverse transform until that block is consumed.

## Interface
- BIT_LENGTH, 15, input coefficient MSB index; inputs are signed BIT_LENGTH+1 bits
- OUT_WIDTH, 16, signed width of each rescaled output coefficient
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input block valid
- in_ready  out  1  block can be accepted this cycle
- qp  in  6  quantizer parameter, sampled on accept
- dc_skip  in  1  sampled on accept; 1 = coefficient 0 passes through unscaled (Intra16x16 DC path)
- quantized  in  [BIT_LENGTH:0] x16  signed levels, index = row*4+col
- out_valid  out  1  rescaled block valid
- out_ready  in  1  downstream accepts block
- dequantized  out  [OUT_WIDTH-1:0] x16  signed rescaled coefficients

## Operation
- States: IDLE, PROC, DONE.
- in_ready = (state==IDLE || (state==DONE && out_ready)) && !reset.
- A block is accepted when in_valid && in_ready. On accept, the block registers capture the 16 levels.
  - qp is clamped to 51 if above 51, then captured.
  - dc_skip is captured.
  - row <= 0; state <= PROC.
- PROC: each cycle computes row `row` (indices row*4..row*4+3) and writes it into dequantized; row increments.
  - On the edge that writes row 3: state <= DONE, out_valid <= 1.
- DONE: dequantized and out_valid hold.
  - If out_ready and no accept: state <= IDLE, out_valid <= 0.
  - If out_ready && in_valid (back-to-back): state <= PROC, out_valid <= 0, new block captured.
- in_valid in PROC is ignored; the source must hold it until in_ready.
- Scale V[qp%6] by position class:
  - class a (0,2,8,10): 10,11,13,14,16,18
  - class b (5,7,13,15): 16,18,20,23,25,29
  - class c (all others): 13,14,16,18,20,23
- Result = (Z * V) << (qp/6).
  - Signed Z times unsigned V; intermediate is at least BIT_LENGTH+1+5+8+1 bits, computed without overflow.
  - Sign follows Z; zero stays zero.
- If captured dc_skip=1, index 0 output = Z sign-extended (or saturated, see Configuration) with no scaling.
- qp/6 and qp%6 are derived from the captured qp, in the range 0..8 and 0..5 respectively.

## Timing
- Reset (asynchronous): state IDLE, row 0, out_valid 0, all dequantized 0, captured qp 0, captured dc_skip 0. in_ready is 0 while reset is high and 1 on the first cycle after release.
- Latency: accept on edge E0 leads to out_valid high after edge E4.
  - dequantized rows 0..3 are written at E1..E4.
  - Intermediate rows are visible but are undefined for use until out_valid.
- Throughput:
  - 1 block per 5 cycles with out_ready held high (back-to-back accept in DONE).
  - 1 block per 6 cycles if downstream consumes before upstream presents.
- Backpressure: out_valid stays high and dequantized is stable for any number of cycles until out_ready.
- Reset asserted mid-PROC or in DONE aborts the block immediately; no partial output is flagged valid.

## Configuration
- DEQUANT_SAT_EN defined: each result is clamped to [-2^(OW-1), 2^(OW-1)-1], where OW = OUT_WIDTH. This also applies to the dc_skip passthrough.
- DEQUANT_SAT_EN not defined: each result is truncated to its low OUT_WIDTH bits (two's-complement wrap).

## Test plan
- qp=28, dc_skip=0, Z[0]=1, Z[1]=2, Z[5]=-3, rest 0 -> dequantized[0]=256, [1]=640, [5]=-1200, rest 0. out_valid rises 4 cycles after accept.
- qp=0, Z[0]=7, Z[15]=-1 -> [0]=70, [15]=-16. qp=60 with Z[0]=1 -> same as qp=51: [0]=14<<8=3584.
- qp=51, Z[5]=100:
  - with DEQUANT_SAT_EN -> [5]=32767
  - without -> [5]=-1024
  - Z[5]=-100 with DEQUANT_SAT_EN -> -32768
- dc_skip=1, qp=28, Z[0]=-5, Z[2]=1 -> [0]=-5, [2]=256. Next block with dc_skip=0 and Z[0]=-5 -> [0]=-1280.
- out_ready low for 10 cycles after out_valid -> outputs stable, in_ready 0. Raise out_ready together with in_valid and a new block -> accept in that cycle, next out_valid 4 edges later.
- Assert reset two cycles after accept -> out_valid 0 and outputs 0 immediately. After release, a fresh block is processed with the correct values.
